mem_bus_arbiter: RTL and testbench

//  Shares the single pipelined memory port (address phase / data phase, trans+ready+resp) between
//  two masters: M0 = core interface, M1 = DMA/debug master. Arbitrates address phases round-robin
//  (or M0-fixed priority), tracks which master owns the in-flight data phase and routes

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter_rr2.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-master pipelined memory bus arbiter:
// transfer types, data-phase owner states and master identifiers.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    function automatic logic [1:0] owner_of(input master_e m);
        return (m == M0) ? OWN_M0 : OWN_M1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-requester address-phase picker: burst lock, then fixed M0 priority
// or round-robin on a tie; a lone requester always wins.
module mem_bus_arbiter_rr2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  master_e    last,
    input  logic       fix,
    input  logic       lock,
    output master_e    pick
);

    logic last_req_s;

    assign last_req_s = (last == M1) ? req[1] : req[0];

    // Lock only holds the bus while the locked master is actually requesting
    always_comb begin
        pick = M0;
        if (lock && last_req_s) begin
            pick = last;
        end else if (req == 2'b11) begin
            pick = fix ? M0 : ((last == M0) ? M1 : M0);
        end else if (req == 2'b10) begin
            pick = M1;
        end else begin
            pick = M0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one pipelined memory port between the core (M0) and DMA/debug (M1),
// tracking the data-phase owner so ready/resp/rdata return to the right master.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DWidth = 32,
    parameter int TWidth = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prio_fix_i,
    input  logic [TWidth-1:0] m0_trans_i,
    input  logic [DWidth-1:0] m0_addr_i,
    input  logic              m0_write_i,
    input  logic [DWidth-1:0] m0_wdata_i,
    input  logic              m0_lock_i,
    output logic              m0_gnt_o,
    output logic              m0_ready_o,
    output logic              m0_resp_o,
    output logic [DWidth-1:0] m0_rdata_o,
    input  logic [TWidth-1:0] m1_trans_i,
    input  logic [DWidth-1:0] m1_addr_i,
    input  logic              m1_write_i,
    input  logic [DWidth-1:0] m1_wdata_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_ready_o,
    output logic              m1_resp_o,
    output logic [DWidth-1:0] m1_rdata_o,
    input  logic              mem_ready_i,
    input  logic              mem_resp_i,
    input  logic [DWidth-1:0] mem_rdata_i,
    output logic [DWidth-1:0] mem_addr_o,
    output logic [TWidth-1:0] mem_trans_o,
    output logic              mem_write_o,
    output logic [DWidth-1:0] mem_wdata_o
);

    logic [1:0]        req_s;
    master_e           pick_s;
    master_e           last_gnt_r;
    logic              lock_r;
    logic [1:0]        owner_r;
    logic [1:0]        owner_nxt_s;
    logic [DWidth-1:0] last_addr_r;
    logic [DWidth-1:0] rdata0_r;
    logic [DWidth-1:0] rdata1_r;
    logic              err_first_s;
    logic              pick_req_s;
    logic              locked_req_s;
    logic              addr_act_s;
    logic              gnt0_s;
    logic              gnt1_s;

    assign req_s = {m1_trans_i == TWidth'(TRANS_NONSEQ), m0_trans_i == TWidth'(TRANS_NONSEQ)};

    mem_bus_arbiter_rr2 u_rr2 (
        .req  (req_s),
        .last (last_gnt_r),
        .fix  (prio_fix_i),
        .lock (lock_r),
        .pick (pick_s)
    );

    // First cycle of a two-cycle error response blanks the address phase
    assign err_first_s  = mem_resp_i & ~mem_ready_i;
    assign pick_req_s   = (pick_s == M1) ? req_s[1] : req_s[0];
    assign locked_req_s = (last_gnt_r == M1) ? req_s[1] : req_s[0];
    assign addr_act_s   = pick_req_s & ~err_first_s;
    assign gnt0_s       = addr_act_s & mem_ready_i & (pick_s == M0);
    assign gnt1_s       = addr_act_s & mem_ready_i & (pick_s == M1);

    assign m0_gnt_o    = gnt0_s;
    assign m1_gnt_o    = gnt1_s;
    assign mem_trans_o = addr_act_s ? TWidth'(TRANS_NONSEQ) : TWidth'(TRANS_IDLE);
    assign mem_addr_o  = !addr_act_s ? last_addr_r : ((pick_s == M1) ? m1_addr_i : m0_addr_i);
    assign mem_write_o = addr_act_s & ((pick_s == M1) ? m1_write_i : m0_write_i);

    assign m0_ready_o = (owner_r == OWN_M0) & mem_ready_i;
    assign m1_ready_o = (owner_r == OWN_M1) & mem_ready_i;
    assign m0_resp_o  = (owner_r == OWN_M0) & mem_resp_i;
    assign m1_resp_o  = (owner_r == OWN_M1) & mem_resp_i;
    assign m0_rdata_o = (owner_r == OWN_M0) ? mem_rdata_i : rdata0_r;
    assign m1_rdata_o = (owner_r == OWN_M1) ? mem_rdata_i : rdata1_r;

    // Write data follows the data-phase owner
    always_comb begin
        mem_wdata_o = {DWidth{1'b0}};
        case (owner_r)
            OWN_M0:  mem_wdata_o = m0_wdata_i;
            OWN_M1:  mem_wdata_o = m1_wdata_i;
            default: mem_wdata_o = {DWidth{1'b0}};
        endcase
    end

    // Next data-phase owner is whoever wins this address phase
    always_comb begin
        owner_nxt_s = OWN_NONE;
        if (gnt0_s || gnt1_s) begin
            owner_nxt_s = owner_of(pick_s);
        end else begin
            owner_nxt_s = OWN_NONE;
        end
    end

    // Owner FSM only advances on an accepted (ready) cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_r <= OWN_NONE;
        end else if (mem_ready_i) begin
            owner_r <= owner_nxt_s;
        end else begin
            owner_r <= owner_r;
        end
    end

    // Arbitration history: last winner, burst lock and last presented address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_r  <= M1;
            lock_r      <= 1'b0;
            last_addr_r <= {DWidth{1'b0}};
        end else if (gnt0_s) begin
            last_gnt_r  <= M0;
            lock_r      <= m0_lock_i;
            last_addr_r <= m0_addr_i;
        end else if (gnt1_s) begin
            last_gnt_r  <= M1;
            lock_r      <= m1_lock_i;
            last_addr_r <= m1_addr_i;
        end else if (mem_ready_i && lock_r && !locked_req_s) begin
            lock_r <= 1'b0;
        end else begin
            lock_r <= lock_r;
        end
    end

    // Keep each master's last completed read data visible after its phase ends
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata0_r <= {DWidth{1'b0}};
            rdata1_r <= {DWidth{1'b0}};
        end else begin
            if (mem_ready_i && (owner_r == OWN_M0)) begin
                rdata0_r <= mem_rdata_i;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (mem_ready_i && (owner_r == OWN_M1)) begin
                rdata1_r <= mem_rdata_i;
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by randomized traffic, every output compared
// each cycle against a behavioural model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic        clk = 1'b0;
    logic        rst_ni, prio_fix;
    logic [1:0]  m0_trans, m1_trans, mem_trans;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        m0_write, m0_lock, m0_gnt, m0_ready, m0_resp;
    logic        m1_write, m1_lock, m1_gnt, m1_ready, m1_resp;
    logic        mem_ready, mem_resp, mem_write;
    logic [31:0] mem_rdata, mem_addr, mem_wdata;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // model state: own = -1 none, 0 = M0, 1 = M1
    int          own, last, m_pick;
    bit          locked;
    logic [31:0] laddr;
    logic [31:0] hold [2];
    bit          m_req [2];
    bit          e_gnt [2];

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni), .prio_fix_i(prio_fix),
        .m0_trans_i(m0_trans), .m0_addr_i(m0_addr), .m0_write_i(m0_write),
        .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt),
        .m0_ready_o(m0_ready), .m0_resp_o(m0_resp), .m0_rdata_o(m0_rdata),
        .m1_trans_i(m1_trans), .m1_addr_i(m1_addr), .m1_write_i(m1_write),
        .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt),
        .m1_ready_o(m1_ready), .m1_resp_o(m1_resp), .m1_rdata_o(m1_rdata),
        .mem_ready_i(mem_ready), .mem_resp_i(mem_resp), .mem_rdata_i(mem_rdata),
        .mem_addr_o(mem_addr), .mem_trans_o(mem_trans), .mem_write_o(mem_write),
        .mem_wdata_o(mem_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own = -1; last = 1; locked = 1'b0; laddr = 32'h0;
        hold[0] = 32'h0; hold[1] = 32'h0;
    endtask

    task automatic model_check();
        bit act;
        logic [31:0] exp_wd;
        if (!rst_ni) model_reset();
        m_req[0] = (m0_trans === NONSEQ);
        m_req[1] = (m1_trans === NONSEQ);
        if (locked && m_req[last])        m_pick = last;
        else if (m_req[0] && m_req[1])    m_pick = prio_fix ? 0 : 1 - last;
        else if (m_req[1])                m_pick = 1;
        else                              m_pick = 0;
        act = m_req[m_pick] && !(mem_resp && !mem_ready);
        e_gnt[0] = act && m_pick == 0 && mem_ready;
        e_gnt[1] = act && m_pick == 1 && mem_ready;
        exp_wd = (own == 0) ? m0_wdata : (own == 1) ? m1_wdata : 32'h0;
        chk("m0_gnt", m0_gnt, e_gnt[0]);
        chk("m1_gnt", m1_gnt, e_gnt[1]);
        chk("mem_trans", mem_trans, act ? NONSEQ : IDLE);
        chk("mem_addr", mem_addr, act ? (m_pick == 0 ? m0_addr : m1_addr) : laddr);
        chk("mem_write", mem_write, act && (m_pick == 0 ? m0_write : m1_write));
        chk("mem_wdata", mem_wdata, exp_wd);
        chk("m0_ready", m0_ready, own == 0 && mem_ready);
        chk("m1_ready", m1_ready, own == 1 && mem_ready);
        chk("m0_resp", m0_resp, own == 0 && mem_resp);
        chk("m1_resp", m1_resp, own == 1 && mem_resp);
        chk("m0_rdata", m0_rdata, own == 0 ? mem_rdata : hold[0]);
        chk("m1_rdata", m1_rdata, own == 1 ? mem_rdata : hold[1]);
    endtask

    task automatic model_update();
        int g;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        if (mem_ready) begin
            if (own >= 0) hold[own] = mem_rdata;
            own = e_gnt[0] ? 0 : (e_gnt[1] ? 1 : -1);
        end
        if (e_gnt[0] || e_gnt[1]) begin
            g = e_gnt[0] ? 0 : 1;
            last = g;
            locked = (g == 0) ? m0_lock : m1_lock;
            laddr = (g == 0) ? m0_addr : m1_addr;
        end else if (mem_ready && locked && !m_req[last]) begin
            locked = 1'b0;
        end
    endtask

    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
        m0_trans = t; m0_addr = a; m0_write = w; m0_lock = l;
    endtask

    task automatic set_m1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
        m1_trans = t; m1_addr = a; m1_write = w; m1_lock = l;
    endtask

    initial begin
        rst_ni = 1'b0; prio_fix = 1'b0;
        set_m0(IDLE, 32'h0, 1'b0, 1'b0); set_m1(IDLE, 32'h0, 1'b0, 1'b0);
        m0_wdata = 32'h0; m1_wdata = 32'h0;
        mem_ready = 1'b1; mem_resp = 1'b0; mem_rdata = 32'h0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_gnt0", m0_gnt, 1'b0);
        chk("rst_trans", mem_trans, IDLE);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rdata0", m0_rdata, 32'h0);
        step();
        rst_ni = 1'b1;

        // 1: single M0 read
        set_m0(NONSEQ, 32'h100, 1'b0, 1'b0);
        #1; chk("t1_gnt0", m0_gnt, 1'b1); chk("t1_addr", mem_addr, 32'h100);
        step();
        set_m0(IDLE, 32'h0, 1'b0, 1'b0); mem_rdata = 32'hDEADBEEF;
        #1; chk("t1_ready0", m0_ready, 1'b1); chk("t1_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("t1_ready1", m1_ready, 1'b0); chk("t1_rdata1", m1_rdata, 32'h0);
        step();

        // 2: round-robin; M0 won last, so M1 leads
        set_m0(NONSEQ, 32'h200, 1'b0, 1'b0); set_m1(NONSEQ, 32'h300, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'h1000 + i;
            #1;
            chk("t2_gnt0", m0_gnt, (i % 2) == 1);
            chk("t2_gnt1", m1_gnt, (i % 2) == 0);
            chk("t2_ready0", m0_ready, i > 0 && (i % 2) == 0);
            chk("t2_ready1", m1_ready, (i % 2) == 1);
            step();
        end
        set_m0(IDLE, 32'h0, 1'b0, 1'b0); set_m1(IDLE, 32'h0, 1'b0, 1'b0);
        step();

        // 3: fixed priority
        prio_fix = 1'b1;
        set_m0(NONSEQ, 32'h400, 1'b0, 1'b0); set_m1(NONSEQ, 32'h500, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1; chk("t3_gnt0", m0_gnt, 1'b1); chk("t3_gnt1", m1_gnt, 1'b0);
            step();
        end
        set_m0(IDLE, 32'h0, 1'b0, 1'b0);
        #1; chk("t3_gnt1_idle0", m1_gnt, 1'b1);
        step();
        set_m1(IDLE, 32'h0, 1'b0, 1'b0); prio_fix = 1'b0;
        step();

        // 4: M1 write with three wait states, M0 waiting
        set_m1(NONSEQ, 32'h20, 1'b1, 1'b0); m1_wdata = 32'h55;
        #1; chk("t4_gnt1", m1_gnt, 1'b1); chk("t4_write", mem_write, 1'b1);
        step();
        set_m1(IDLE, 32'h0, 1'b0, 1'b0); set_m0(NONSEQ, 32'h40, 1'b0, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("t4_ws_gnt0", m0_gnt, 1'b0); chk("t4_ws_wdata", mem_wdata, 32'h55);
            chk("t4_ws_ready1", m1_ready, 1'b0);
            step();
        end
        mem_ready = 1'b1;
        #1; chk("t4_ready1", m1_ready, 1'b1); chk("t4_b2b_gnt0", m0_gnt, 1'b1);
        step();
        set_m0(IDLE, 32'h0, 1'b0, 1'b0);
        step();

        // 5: two-cycle error on an M0 read
        set_m0(NONSEQ, 32'h80, 1'b0, 1'b0);
        step();
        set_m0(IDLE, 32'h0, 1'b0, 1'b0); set_m1(NONSEQ, 32'h90, 1'b0, 1'b0);
        mem_resp = 1'b1; mem_ready = 1'b0;
        #1; chk("t5_resp0_c1", m0_resp, 1'b1); chk("t5_gnt1_c1", m1_gnt, 1'b0);
        chk("t5_trans_c1", mem_trans, IDLE);
        step();
        mem_ready = 1'b1;
        #1; chk("t5_resp0_c2", m0_resp, 1'b1); chk("t5_ready0_c2", m0_ready, 1'b1);
        chk("t5_gnt1_c2", m1_gnt, 1'b1);
        step();
        mem_resp = 1'b0; set_m1(IDLE, 32'h0, 1'b0, 1'b0);
        step();

        // 6: M1 lock holds three grants against M0, then reset mid-transfer
        set_m1(NONSEQ, 32'hA0, 1'b0, 1'b1);
        #1; chk("t6_gnt1_a", m1_gnt, 1'b1);
        step();
        set_m0(NONSEQ, 32'hB0, 1'b0, 1'b0); set_m1(NONSEQ, 32'hA4, 1'b0, 1'b1);
        #1; chk("t6_gnt1_b", m1_gnt, 1'b1);
        step();
        set_m1(NONSEQ, 32'hA8, 1'b0, 1'b0);
        #1; chk("t6_gnt1_c", m1_gnt, 1'b1); chk("t6_gnt0_c", m0_gnt, 1'b0);
        step();
        set_m1(NONSEQ, 32'hAC, 1'b0, 1'b0);
        #1; chk("t6_gnt0_d", m0_gnt, 1'b1); chk("t6_gnt1_d", m1_gnt, 1'b0);
        step();
        rst_ni = 1'b0;
        set_m0(IDLE, 32'h0, 1'b0, 1'b0); set_m1(IDLE, 32'h0, 1'b0, 1'b0);
        #1; chk("t6_rst_ready0", m0_ready, 1'b0); chk("t6_rst_addr", mem_addr, 32'h0);
        chk("t6_rst_rdata0", m0_rdata, 32'h0); chk("t6_rst_rdata1", m1_rdata, 32'h0);
        chk("t6_rst_wdata", mem_wdata, 32'h0);
        step();
        rst_ni = 1'b1;
        step();

        // randomized traffic; masters hold a request until the model grants it
        for (int c = 0; c < 400; c++) begin
            if (m0_trans != NONSEQ && $urandom_range(1, 0) == 1)
                set_m0(NONSEQ, $urandom, 1'($urandom), $urandom_range(3, 0) == 0);
            if (m1_trans != NONSEQ && $urandom_range(1, 0) == 1)
                set_m1(NONSEQ, $urandom, 1'($urandom), $urandom_range(3, 0) == 0);
            m0_wdata = $urandom; m1_wdata = $urandom; mem_rdata = $urandom;
            mem_ready = ($urandom_range(3, 0) != 0);
            mem_resp = ($urandom_range(7, 0) == 0);
            if ((c % 16) == 0) prio_fix = 1'($urandom);
            step();
            if (e_gnt[0]) set_m0(IDLE, $urandom, 1'b0, 1'b0);
            if (e_gnt[1]) set_m1(IDLE, $urandom, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
